// File: rtl/branch_predictor_pkg.sv
// rtl/branch_predictor_pkg.sv - shared constants and counter encodings for branch_predictor
package branch_predictor_pkg;

    localparam int LENGTH_DEFAULT = 32;
    localparam int MODE_STATIC    = 0;
    localparam int MODE_BIMODAL   = 1;

    // Weakly-taken: MSB set, remaining bits clear (CNT_W=1 gives 1).
    function automatic logic [31:0] weaklyTaken(input int cntW);
        return 32'(1) << (cntW - 1);
    endfunction

    // Weakly-not-taken: MSB clear, remaining bits set (CNT_W=1 gives 0).
    function automatic logic [31:0] weaklyNotTaken(input int cntW);
        return (32'(1) << (cntW - 1)) - 32'(1);
    endfunction

endpackage

// File: rtl/branch_predictor_sat_counter.sv
// rtl/branch_predictor_sat_counter.sv - saturating up/down counter next-value logic
module sat_counter #(
    parameter int CNT_W = 2
) (
    input  logic [CNT_W-1:0] cnt,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] nextCnt
);

    always_comb begin
        nextCnt = cnt;
        if (inc && !dec && (cnt != '1)) begin
            nextCnt = cnt + CNT_W'(1);
        end else if (dec && !inc && (cnt != '0)) begin
            nextCnt = cnt - CNT_W'(1);
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - direct-mapped bimodal branch predictor for the fetch stage
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int LENGTH  = LENGTH_DEFAULT,
    parameter int ENTRIES = 16,
    parameter int TAG_W   = 8,
    parameter int CNT_W   = 2,
    parameter int MODE    = MODE_BIMODAL,
    parameter int STAT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [LENGTH-1:0] lookup_pc_in,
    output logic              predict_taken_out,
    output logic [LENGTH-1:0] predict_target_out,
    input  logic              update_valid_in,
    input  logic [LENGTH-1:0] update_pc_in,
    input  logic              update_taken_in,
    input  logic [LENGTH-1:0] update_target_in,
    input  logic              update_pred_taken_in,
    input  logic [LENGTH-1:0] update_pred_target_in,
    output logic              mispredict_out,
    output logic [LENGTH-1:0] recover_pc_out,
    output logic [STAT_W-1:0] branch_count_out,
    output logic [STAT_W-1:0] mispredict_count_out
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam logic [CNT_W-1:0] CNT_WEAK_T  = CNT_W'(weaklyTaken(CNT_W));
    localparam logic [CNT_W-1:0] CNT_WEAK_NT = CNT_W'(weaklyNotTaken(CNT_W));

    // Plain register array so reset can clear every valid bit at once.
    logic              validQ  [ENTRIES];
    logic [TAG_W-1:0]  tagQ    [ENTRIES];
    logic [LENGTH-1:0] targetQ [ENTRIES];
    logic [CNT_W-1:0]  cntQ    [ENTRIES];

    logic [STAT_W-1:0] branchCount;
    logic [STAT_W-1:0] mispredictCount;

    logic [IDX_W-1:0] lookIdx;
    logic [IDX_W-1:0] updIdx;
    logic [TAG_W-1:0] lookTag;
    logic [TAG_W-1:0] updTag;
    logic             lookHit;
    logic             updHit;
    logic [CNT_W-1:0] cntNext;

    assign lookIdx = lookup_pc_in[IDX_W+1:2];
    assign lookTag = lookup_pc_in[IDX_W+TAG_W+1:IDX_W+2];
    assign updIdx  = update_pc_in[IDX_W+1:2];
    assign updTag  = update_pc_in[IDX_W+TAG_W+1:IDX_W+2];

    assign lookHit = validQ[lookIdx] && (tagQ[lookIdx] == lookTag);
    assign updHit  = validQ[updIdx] && (tagQ[updIdx] == updTag);

    assign predict_taken_out  = (MODE == MODE_BIMODAL) && lookHit && cntQ[lookIdx][CNT_W-1];
    assign predict_target_out = predict_taken_out ? targetQ[lookIdx] : lookup_pc_in + LENGTH'(4);

    assign mispredict_out = update_valid_in &&
        ((update_taken_in != update_pred_taken_in) ||
         (update_taken_in && update_pred_taken_in && (update_target_in != update_pred_target_in)));
    assign recover_pc_out = update_taken_in ? update_target_in : update_pc_in + LENGTH'(4);

    sat_counter #(.CNT_W(CNT_W)) u_sat_counter (
        .cnt     (cntQ[updIdx]),
        .inc     (update_taken_in),
        .dec     (!update_taken_in),
        .nextCnt (cntNext)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                validQ[i] <= 1'b0;
                cntQ[i]   <= CNT_WEAK_NT;
            end
            branchCount     <= '0;
            mispredictCount <= '0;
        end else if (update_valid_in) begin
            if (updHit) begin
                cntQ[updIdx] <= cntNext;
                if (update_taken_in) begin
                    targetQ[updIdx] <= update_target_in;
                end
            end else if (update_taken_in) begin
                validQ[updIdx]  <= 1'b1;
                tagQ[updIdx]    <= updTag;
                targetQ[updIdx] <= update_target_in;
                cntQ[updIdx]    <= CNT_WEAK_T;
            end
            if (branchCount != '1) begin
                branchCount <= branchCount + STAT_W'(1);
            end
            if (mispredict_out && (mispredictCount != '1)) begin
                mispredictCount <= mispredictCount + STAT_W'(1);
            end
        end
    end

    assign branch_count_out     = branchCount;
    assign mispredict_count_out = mispredictCount;

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - self-checking bench for branch_predictor (bimodal and static builds)
module tb_branch_predictor;

    logic        clk;
    logic        rst;
    logic        rst0;
    logic [31:0] lookPc;
    logic        updValid;
    logic        updValid0;
    logic [31:0] updPc;
    logic        updTaken;
    logic [31:0] updTarget;
    logic        updPredTaken;
    logic [31:0] updPredTarget;

    logic        predTaken,  predTaken0;
    logic [31:0] predTarget, predTarget0;
    logic        misp,       misp0;
    logic [31:0] recov,      recov0;
    logic [15:0] bCnt,       bCnt0;
    logic [15:0] mCnt,       mCnt0;

    int checks   = 0;
    int failures = 0;

    // Reference table for the bimodal build, counters kept as plain integers 0..3.
    bit          mValid  [16];
    int          mCtr    [16];
    logic [7:0]  mTag    [16];
    logic [31:0] mTarget [16];
    int          expBr;
    int          expMp;

    branch_predictor #(.MODE(1)) dut (
        .clk(clk), .rst(rst), .lookup_pc_in(lookPc),
        .predict_taken_out(predTaken), .predict_target_out(predTarget),
        .update_valid_in(updValid), .update_pc_in(updPc), .update_taken_in(updTaken),
        .update_target_in(updTarget), .update_pred_taken_in(updPredTaken),
        .update_pred_target_in(updPredTarget), .mispredict_out(misp),
        .recover_pc_out(recov), .branch_count_out(bCnt), .mispredict_count_out(mCnt)
    );

    branch_predictor #(.MODE(0)) dut0 (
        .clk(clk), .rst(rst0), .lookup_pc_in(lookPc),
        .predict_taken_out(predTaken0), .predict_target_out(predTarget0),
        .update_valid_in(updValid0), .update_pc_in(updPc), .update_taken_in(updTaken),
        .update_target_in(updTarget), .update_pred_taken_in(updPredTaken),
        .update_pred_target_in(updPredTarget), .mispredict_out(misp0),
        .recover_pc_out(recov0), .branch_count_out(bCnt0), .mispredict_count_out(mCnt0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int idxOf(input logic [31:0] pc);
        return int'((pc / 4) % 16);
    endfunction

    function automatic logic [7:0] tagOf(input logic [31:0] pc);
        return 8'((pc / 64) % 256);
    endfunction

    function automatic void modelPredict(input logic [31:0] pc, output logic t, output logic [31:0] tgt);
        int i = idxOf(pc);
        t   = mValid[i] && (mTag[i] == tagOf(pc)) && (mCtr[i] >= 2);
        tgt = t ? mTarget[i] : pc + 32'd4;
    endfunction

    function automatic void modelReset();
        for (int i = 0; i < 16; i++) begin
            mValid[i] = 1'b0;
            mCtr[i]   = 1;
        end
        expBr = 0;
        expMp = 0;
    endfunction

    function automatic void modelUpdate(input bit wasMisp);
        int i = idxOf(updPc);
        if (expBr < 65535) expBr++;
        if (wasMisp && expMp < 65535) expMp++;
        if (mValid[i] && mTag[i] == tagOf(updPc)) begin
            mCtr[i] = updTaken ? ((mCtr[i] + 1 > 3) ? 3 : mCtr[i] + 1)
                               : ((mCtr[i] - 1 < 0) ? 0 : mCtr[i] - 1);
            if (updTaken) mTarget[i] = updTarget;
        end else if (updTaken) begin
            mValid[i]  = 1'b1;
            mTag[i]    = tagOf(updPc);
            mTarget[i] = updTarget;
            mCtr[i]    = 2;
        end
    endfunction

    task automatic setUpd(input bit v, input logic [31:0] pc, input bit t, input logic [31:0] tgt,
                          input bit pt, input logic [31:0] ptgt);
        updValid = v; updPc = pc; updTaken = t; updTarget = tgt;
        updPredTaken = pt; updPredTarget = ptgt;
    endtask

    // Called at the negedge with inputs already driven: checks, clocks once, checks stats.
    task automatic tick();
        logic        expT;
        logic [31:0] expTgt;
        bit          expM;
        #1;
        modelPredict(lookPc, expT, expTgt);
        chk("predict_taken", predTaken, expT);
        chk("predict_target", predTarget, expTgt);
        chk("static_taken", predTaken0, 0);
        expM = updValid && ((updTaken != updPredTaken) || (updTaken && updTarget != updPredTarget));
        chk("mispredict", misp, expM);
        if (updValid) chk("recover_pc", recov, updTaken ? updTarget : updPc + 32'd4);
        @(posedge clk);
        if (rst) modelReset();
        else if (updValid) modelUpdate(expM);
        @(negedge clk);
        chk("branch_count", bCnt, expBr);
        chk("mispredict_count", mCnt, expMp);
    endtask

    initial begin
        int n;
        rst = 1'b1; rst0 = 1'b1; lookPc = 32'h40; updValid0 = 1'b0;
        setUpd(0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        modelReset();
        @(negedge clk);
        rst = 1'b0; rst0 = 1'b0;
        #1;
        chk("reset_taken", predTaken, 0);
        chk("reset_target", predTarget, 32'h44);
        chk("reset_branch_count", bCnt, 0);
        chk("reset_mispredict_count", mCnt, 0);

        // First taken branch allocates the entry.
        setUpd(1, 32'h40, 1, 32'h80, 0, 32'h44);
        #1;
        chk("alloc_mispredict", misp, 1);
        chk("alloc_recover", recov, 32'h80);
        tick();
        updValid = 1'b0;
        #1;
        chk("alloc_lookup_taken", predTaken, 1);
        chk("alloc_lookup_target", predTarget, 32'h80);
        chk("alloc_mispredict_count", mCnt, 1);
        tick();

        // Saturate, then walk back down through the taken threshold.
        setUpd(1, 32'h40, 1, 32'h80, 1, 32'h80);
        repeat (3) tick();
        setUpd(1, 32'h40, 0, 32'h80, 1, 32'h80);
        tick();
        updValid = 1'b0;
        #1 chk("ctr10_taken", predTaken, 1);
        setUpd(1, 32'h40, 0, 32'h80, 1, 32'h80);
        tick();
        updValid = 1'b0;
        #1 chk("ctr01_target", predTarget, 32'h44);
        tick();

        // Alias at index 0 with a different tag.
        setUpd(1, 32'h40, 1, 32'h80, 0, 32'h44);
        tick();
        lookPc = 32'h440; updValid = 1'b0;
        #1 chk("alias_target", predTarget, 32'h444);
        tick();
        setUpd(1, 32'h440, 1, 32'h500, 0, 32'h444);
        tick();
        updValid = 1'b0; lookPc = 32'h40;
        #1 chk("alias_evicted", predTaken, 0);
        tick();

        // Same-cycle update and lookup sees pre-update contents.
        setUpd(1, 32'h40, 1, 32'h80, 0, 32'h44);
        #1 chk("same_cycle_taken", predTaken, 0);
        tick();
        updValid = 1'b0;
        #1 chk("next_cycle_taken", predTaken, 1);
        tick();

        // Reset wins over a simultaneous update.
        rst = 1'b1;
        setUpd(1, 32'h80, 1, 32'h100, 0, 32'h84);
        tick();
        rst = 1'b0; updValid = 1'b0; lookPc = 32'h80;
        #1 chk("rst_drop_update", predTaken, 0);
        tick();

        // Randomized traffic over a small PC window so aliases and hits are frequent.
        for (int k = 0; k < 400; k++) begin
            logic        mt;
            logic [31:0] mtg;
            lookPc = 32'($urandom_range(0, 255)) * 4;
            setUpd($urandom_range(0, 3) != 0, 32'($urandom_range(0, 255)) * 4, 1'($urandom_range(0, 1)),
                   32'($urandom_range(0, 15)) * 4 + 32'h1000, 0, 0);
            modelPredict(updPc, mt, mtg);
            if ($urandom_range(0, 1) == 1) begin
                updPredTaken = mt; updPredTarget = mtg;
            end else begin
                updPredTaken = 1'($urandom_range(0, 1));
                updPredTarget = $urandom_range(0, 1) ? updTarget : 32'($urandom_range(0, 15)) * 4 + 32'h1000;
            end
            rst = ($urandom_range(0, 99) == 0);
            tick();
            rst = 1'b0;
        end

        // Static build: stats saturate, mid-stream reset clears them.
        updValid = 1'b0; updValid0 = 1'b1;
        updTaken = 1'b1; updPredTaken = 1'b0; updTarget = 32'h2000; updPredTarget = 32'h0;
        n = 0;
        for (int k = 0; k < 70000; k++) begin
            updPc  = 32'($urandom_range(0, 1023)) * 4;
            lookPc = updPc;
            rst0   = (k == 100);
            #1;
            chk("static_predict", predTaken0, 0);
            chk("static_mispredict", misp0, 1);
            @(posedge clk);
            n = rst0 ? 0 : n + 1;
            @(negedge clk);
            if (k == 100 || k % 97 == 0 || k > 69990) begin
                chk("static_branch_count", bCnt0, (n > 65535) ? 65535 : n);
                chk("static_mispredict_count", mCnt0, (n > 65535) ? 65535 : n);
            end
        end
        rst0 = 1'b0; updValid0 = 1'b0;
        chk("static_branch_sat", bCnt0, 16'hFFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Dynamic branch predictor for the IF stage of the 5-stage pipeline; replaces the fixed "predict not-taken, redirect from D" scheme.
- Holds a direct-mapped table per entry: valid bit, tag, target and saturating counter, sized by parameter.
- Looks up pcF combinationally to supply a predicted next PC.
- Takes the resolved outcome from ID (BranchD and is_equal) and flags mispredicts with a recovery PC.
- Counts branches and mispredicts for performance evaluation.

Parameters:
- LENGTH, 32, datapath/PC width.
- ENTRIES, 16, table entries; power of two, at least 2. IDX_W = log2(ENTRIES).
- TAG_W, 8, tag bits stored per entry.
- CNT_W, 2, saturating-counter width, at least 1.
- MODE, 1, predictor mode: 0 = static not-taken (table still trained, prediction forced 0); 1 = bimodal.
- STAT_W, 16, width of the performance counters.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- lookup_pc_in  in  LENGTH  fetch PC (pcF).
- predict_taken_out  out  1  predicted taken for lookup_pc_in.
- predict_target_out  out  LENGTH  predicted target; equals lookup_pc_in+4 when predict_taken_out=0.
- update_valid_in  in  1  a branch resolved in D this cycle; qualified by the pipeline with ~stallD.
- update_pc_in  in  LENGTH  PC of the resolved branch (pc_4D-4).
- update_taken_in  in  1  actual outcome.
- update_target_in  in  LENGTH  actual branch target.
- update_pred_taken_in  in  1  prediction carried through IF/ID.
- update_pred_target_in  in  LENGTH  predicted target carried through IF/ID.
- mispredict_out  out  1  combinational; the IF/ID flush and PC redirect request.
- recover_pc_out  out  LENGTH  correct next PC when mispredict_out=1.
- branch_count_out  out  STAT_W  resolved branches.
- mispredict_count_out  out  STAT_W  mispredicts.

Behaviour:
- Address fields:
  - index = pc[IDX_W+1:2].
  - tag = pc[IDX_W+TAG_W+1:IDX_W+2].
  - pc[1:0] is ignored.
- Lookup (combinational, 0 latency):
  - hit = valid[index] & (tag[index] == lookup tag).
  - predict_taken_out = MODE==1 & hit & counter MSB.
  - predict_target_out = stored target if predict_taken_out=1, else lookup_pc_in+4 (mod 2^LENGTH).
- Mispredict detection (combinational):
  - mispredict_out = update_valid_in & ((update_taken_in != update_pred_taken_in) | (update_taken_in & update_pred_taken_in & update_target_in != update_pred_target_in)).
  - recover_pc_out = update_target_in if update_taken_in=1, else update_pc_in+4.
- Update, on the clk edge when update_valid_in=1:
  - Hit: counter +1 if taken (saturates at all-ones), -1 if not taken (saturates at 0). If taken, the target is overwritten.
  - Miss and taken: allocate the entry, overwriting it unconditionally: valid=1, tag, target, counter = weakly-taken (MSB=1, rest 0).
  - Miss and not taken: no table change.
- Same-cycle lookup and update of the same index: the lookup sees the pre-update contents. No bypass.
- Stats: both counters saturate at all-ones; they do not wrap.
  - branch_count_out +1 per update_valid_in.
  - mispredict_count_out +1 per mispredict_out.
- Reset (synchronous, rst=1 at the edge):
  - All valid bits cleared.
  - All counters set to weakly-not-taken (MSB=0, rest 1).
  - Targets and tags are don't-care.
  - Stats cleared to 0.
  - After reset: predict_taken_out=0, predict_target_out=lookup_pc_in+4, mispredict_out follows its inputs.
- rst has priority over a simultaneous update; the update is dropped.
- MODE=0: predict_taken_out is always 0. Training and stats still run, so mispredict_out equals update_valid_in & update_taken_in.
- CNT_W=1: the counter is the taken bit itself.
  - Allocate sets it to 1.
  - Reset sets it to 0.

Decomposition:
- Package: LENGTH default, counter encodings (weakly-taken, weakly-not-taken as functions of CNT_W), MODE encodings (MODE_STATIC=0, MODE_BIMODAL=1).
- One sub-module: sat_counter. Parameter CNT_W; inputs inc/dec; output next value with saturation. Instantiated once in the update path.
- Storage is a register array with no memory macro, so reset can clear the valid bits.

Test Plan:
- Reset, then lookup 0x0000_0040: predict_taken_out=0, predict_target_out=0x0000_0044; both stats=0.
- Update pc=0x40, taken=1, target=0x80, pred_taken=0: mispredict_out=1, recover_pc_out=0x80. Next cycle, lookup 0x40 gives taken=1, target=0x80; mispredict_count=1.
- Train 0x40 taken three more times (counter saturates at 11), then one not-taken: the counter is 10 and lookup still predicts taken. A second not-taken gives 01 and lookup predicts 0x44.
- Alias: with 0x40 allocated, lookup 0x440 (same index 0, different tag) gives not-taken/0x444. An update of 0x440 taken, target=0x500, replaces the entry, and a subsequent lookup of 0x40 misses.
- Same-cycle update of 0x40 taken/0x80 and lookup 0x40: the lookup in that cycle returns not-taken, and the next cycle returns taken.
- MODE=0 build, 70000 taken updates: predict_taken_out is always 0; both stats stop at 0xFFFF. A reset mid-stream (rst=1 with update_valid_in=1) leaves counts at 0 and all entries invalid.
